serdesphy_cdr_vco_ctrl: RTL
===========================

// Module: serdesphy_cdr_vco_ctrl
// PURPOSE
//   Digital sequencer and loop filter for the RX CDR VCO. Powers the VCO up in order, waits for vco_ready,
//   holds the control word during settling, then integrates phase-detector up/dn pulses into the 8-bit
//   cdr_control word. It also reports lock and fault status to the PHY control/status block.
// PARAMETERS
//   RST_CYCLES     4     cycles vco_rst_n is held low after vco_enable rises
//   READY_TIMEOUT  1024  max cycles in WAIT_READY before FAULT
//   SETTLE_CYCLES  256   cycles control word is frozen after ready
//   ACC_THRESH     8     integrator magnitude that triggers a +/-1 control step (>=2)
//   LOCK_CYCLES    512   consecutive non-saturated TRACK cycles required for cdr_locked
//   CTRL_MIN       8     lower clamp of cdr_control
//   CTRL_MAX       247   upper clamp of cdr_control
// PORTS
//   clk            in   1  PHY digital clock
//   rst            in   1  synchronous active-high reset
//   cdr_en         in   1  level request to run the CDR loop
//   cfg_init_code  in   8  starting control word, sampled on OFF->PWRUP
//   pd_up          in   1  phase detector "early" pulse (clk domain)
//   pd_dn          in   1  phase detector "late" pulse (clk domain)
//   vco_ready      in   1  VCO stable flag (asynchronous; 2-flop synchronised internally)
//   vco_enable     out  1  VCO enable
//   vco_rst_n      out  1  VCO active-low reset
//   cdr_control    out  8  VCO control word
//   cdr_locked     out  1  loop lock indication
//   cdr_fault      out  1  sticky fault until cdr_en drops
//   ctrl_state     out  3  current FSM state encoding (debug)
// BEHAVIOUR
//   Reset: state=OFF; vco_enable=0, vco_rst_n=0, cdr_control=128, cdr_locked=0, cdr_fault=0, counters/acc=0.
//   States (ctrl_state): OFF=0, PWRUP=1, WAIT_READY=2, SETTLE=3, TRACK=4, FAULT=5.
//   cdr_en=0 in any state -> OFF next cycle (highest priority); all outputs return to reset values except
//     cdr_control holds its last value.
//   OFF: cdr_en=1 -> PWRUP; load cdr_control=clamp(cfg_init_code,CTRL_MIN,CTRL_MAX); timer=0.
//   PWRUP: vco_enable=1, vco_rst_n=0 for exactly RST_CYCLES cycles, then WAIT_READY.
//   WAIT_READY: vco_enable=1, vco_rst_n=1; timer counts. ready_s (synchronised, +2 cycles) =1 -> SETTLE.
//     If timer reaches READY_TIMEOUT-1 without ready_s -> FAULT. If both happen the same cycle, ready wins.
//   SETTLE: cdr_control frozen, pd inputs ignored, acc held at 0; after SETTLE_CYCLES cycles -> TRACK.
//   TRACK: signed integrator acc (width clog2(ACC_THRESH)+2):
//     pd_up&!pd_dn: acc+1; pd_dn&!pd_up: acc-1; both or neither: no change.
//     When the next acc value would reach +ACC_THRESH: cdr_control+1 and acc=0 in that cycle.
//     When it would reach -ACC_THRESH: cdr_control-1 and acc=0 in that cycle.
//     A step beyond CTRL_MAX/CTRL_MIN is clamped (no wrap). The clamped attempt counts as saturation.
//   Lock: lock_cnt increments each TRACK cycle without saturation; saturation clears lock_cnt and cdr_locked.
//     cdr_locked=1 when lock_cnt reaches LOCK_CYCLES (lock_cnt saturates). cdr_locked=0 outside TRACK.
//   ready_s falling in SETTLE or TRACK -> FAULT next cycle.
//   FAULT: vco_enable=0, vco_rst_n=0, cdr_fault=1, cdr_locked=0; leave only via cdr_en=0 (-> OFF, fault clears).
//   rst asserted mid-operation: all state returns to reset values on the next edge (cdr_control=128).
//   Outputs are all registered; cdr_control changes 1 cycle after the pd pulse that crosses threshold.
// TESTING
//   Bring-up: init=100, cdr_en=1, vco_ready rises 10 cycles later -> PWRUP 4 cycles, SETTLE, TRACK; control=100.
//   Integrator: 8 consecutive pd_up pulses in TRACK -> control 100->101, acc=0. 8 pd_dn -> back to 100. Both-high -> no change.
//   Clamp: init=250 -> loads 247. pd_up bursts -> stays 247, lock_cnt clears, cdr_locked stays 0.
//   Lock: alternating up/dn for 600 TRACK cycles -> cdr_locked=1 at TRACK cycle 512, control constant.
//   Timeout: vco_ready held 0 -> FAULT after 1024 WAIT_READY cycles, cdr_fault=1; cdr_en=0 -> OFF, fault clears.
//   Disruption: drop vco_ready in TRACK -> FAULT. Separately, drop cdr_en in SETTLE -> OFF. Assert rst in TRACK -> control=128.

Source files
------------

// File: rtl/serdesphy_cdr_vco_ctrl.sv
// RX CDR VCO sequencer and loop filter: powers the VCO up in order, then integrates
// phase-detector pulses into a clamped 8-bit control word and reports lock/fault status.
module serdesphy_cdr_vco_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int READY_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int ACC_THRESH    = 8,
    parameter int LOCK_CYCLES   = 512,
    parameter int CTRL_MIN      = 8,
    parameter int CTRL_MAX      = 247
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cdr_en,
    input  logic [7:0] cfg_init_code,
    input  logic       pd_up,
    input  logic       pd_dn,
    input  logic       vco_ready,
    output logic       vco_enable,
    output logic       vco_rst_n,
    output logic [7:0] cdr_control,
    output logic       cdr_locked,
    output logic       cdr_fault,
    output logic [2:0] ctrl_state
);

    localparam int ACC_W   = $clog2(ACC_THRESH) + 2;
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int TMR_MAX = (READY_TIMEOUT > SETTLE_CYCLES)
                           ? ((READY_TIMEOUT > RST_CYCLES) ? READY_TIMEOUT : RST_CYCLES)
                           : ((SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic signed [ACC_W-1:0] ACC_POS  = ACC_W'(ACC_THRESH);
    localparam logic signed [ACC_W-1:0] ACC_NEG  = ACC_W'(-ACC_THRESH);
    localparam logic [LOCK_W-1:0]       LOCK_TOP = LOCK_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWRUP      = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_TRACK      = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    state_t                   state, state_nxt;
    logic [TMR_W-1:0]         timer, timer_nxt;
    logic [7:0]               ctrl_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt, acc_sum, pd_delta;
    logic [LOCK_W-1:0]        lock_cnt, lock_nxt;
    logic                     sat;
    logic                     ready_p0, ready_p1;
    logic                     ready_s;

    function automatic logic [7:0] clamp_ctrl(input logic [7:0] v);
        if (v < 8'(CTRL_MIN))      return 8'(CTRL_MIN);
        else if (v > 8'(CTRL_MAX)) return 8'(CTRL_MAX);
        else                       return v;
    endfunction

    // A step that would leave [CTRL_MIN, CTRL_MAX] is suppressed and reported as saturation.
    function automatic logic step_sat(input logic [7:0] v, input logic up);
        return up ? (v >= 8'(CTRL_MAX)) : (v <= 8'(CTRL_MIN));
    endfunction

    assign ready_s    = ready_p1;
    assign ctrl_state = state;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ctrl_nxt  = cdr_control;
        acc_nxt   = '0;
        lock_nxt  = '0;
        acc_sum   = '0;
        pd_delta  = '0;
        sat       = 1'b0;
        if (pd_up && !pd_dn)      pd_delta = ACC_W'(1);
        else if (pd_dn && !pd_up) pd_delta = '1;
        if (!cdr_en) begin
            state_nxt = ST_OFF;
            timer_nxt = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = ST_PWRUP;
                    timer_nxt = '0;
                    ctrl_nxt  = clamp_ctrl(cfg_init_code);
                end
                ST_PWRUP: begin
                    if (timer == TMR_W'(RST_CYCLES - 1)) begin
                        state_nxt = ST_WAIT_READY;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    // ready takes priority over a simultaneous timeout
                    if (ready_s) begin
                        state_nxt = ST_SETTLE;
                        timer_nxt = '0;
                    end else if (timer == TMR_W'(READY_TIMEOUT - 1)) begin
                        state_nxt = ST_FAULT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!ready_s) begin
                        state_nxt = ST_FAULT;
                        timer_nxt = '0;
                    end else if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
                        state_nxt = ST_TRACK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (!ready_s) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        acc_sum = acc + pd_delta;
                        acc_nxt = acc_sum;
                        if (acc_sum == ACC_POS) begin
                            acc_nxt = '0;
                            sat     = step_sat(cdr_control, 1'b1);
                            if (!sat) ctrl_nxt = cdr_control + 8'd1;
                        end else if (acc_sum == ACC_NEG) begin
                            acc_nxt = '0;
                            sat     = step_sat(cdr_control, 1'b0);
                            if (!sat) ctrl_nxt = cdr_control - 8'd1;
                        end
                        if (sat)                       lock_nxt = '0;
                        else if (lock_cnt != LOCK_TOP) lock_nxt = lock_cnt + 1'b1;
                        else                           lock_nxt = lock_cnt;
                    end
                end
                ST_FAULT: state_nxt = ST_FAULT;
                default: begin
                    state_nxt = ST_OFF;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Stage p0/p1: vco_ready synchroniser; status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OFF;
            timer       <= '0;
            cdr_control <= 8'd128;
            acc         <= '0;
            lock_cnt    <= '0;
            vco_enable  <= 1'b0;
            vco_rst_n   <= 1'b0;
            cdr_locked  <= 1'b0;
            cdr_fault   <= 1'b0;
            ready_p0    <= 1'b0;
            ready_p1    <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cdr_control <= ctrl_nxt;
            acc         <= acc_nxt;
            lock_cnt    <= lock_nxt;
            vco_enable  <= (state_nxt == ST_PWRUP) || (state_nxt == ST_WAIT_READY) ||
                           (state_nxt == ST_SETTLE) || (state_nxt == ST_TRACK);
            vco_rst_n   <= (state_nxt == ST_WAIT_READY) || (state_nxt == ST_SETTLE) ||
                           (state_nxt == ST_TRACK);
            cdr_locked  <= (state_nxt == ST_TRACK) && (lock_nxt == LOCK_TOP);
            cdr_fault   <= (state_nxt == ST_FAULT);
            ready_p0    <= vco_ready;
            ready_p1    <= ready_p0;
        end
    end

endmodule
